imm_gen_reg: RTL

- Registered, parametrised immediate generator for the multi-cycle RV core.
- Latches the fetched instruction on an IR-write strobe and decodes its format.
- Produces a sign/zero-extended immediate of width XLEN behind a valid/ack handshake.
- Adds over the current combinational generator: XLEN generalisation (32/64), a shamt format, illegal-opcode flagging, an optional output pipeline stage, and hold-until-consumed semantics.

---
 rtl/imm_gen_reg.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/imm_gen_reg.sv
// Registered RISC-V immediate generator: latches IR on ir_write, decodes format, holds result until acked.
// Latency: imm_valid 2 edges after the ir_write cycle with REG_OUT=1, 1 edge with REG_OUT=0; ir_write always wins over imm_ack.
module imm_gen_reg #(
    parameter int XLEN    = 32,
    parameter bit REG_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_in,
    input  logic            ir_write,
    input  logic            imm_ack,
    output logic [31:0]     instr_q,
    output logic [XLEN-1:0] imm_out,
    output logic [2:0]      imm_fmt,
    output logic            illegal,
    output logic            imm_valid
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_HOLD} state_t;

    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_NONE  = 3'd7;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_ir;
    logic [XLEN-1:0]   r_imm;
    logic [2:0]        r_fmt;
    logic              r_illegal;

    logic [31:0]       w_src;
    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic [2:0]        w_fmt;
    logic              w_illegal;
    logic              w_load;
    logic              w_valid;

    // With no output stage the decoder sees the word being captured, so results land on the capture edge.
    assign w_src = REG_OUT ? r_ir : instr_in;

    always_comb begin
        w_imm32   = '0;
        w_fmt     = FMT_NONE;
        w_illegal = 1'b1;
        unique case (w_src[6:0])
            7'h03, 7'h67: begin
                w_imm32   = {{20{w_src[31]}}, w_src[31:20]};
                w_fmt     = FMT_I;
                w_illegal = 1'b0;
            end
            7'h13: begin
                w_illegal = 1'b0;
                if (w_src[14:12] == 3'b001 || w_src[14:12] == 3'b101) begin
                    w_imm32 = {26'b0, (XLEN == 64) ? w_src[25] : 1'b0, w_src[24:20]};
                    w_fmt   = FMT_SHAMT;
                end else begin
                    w_imm32 = {{20{w_src[31]}}, w_src[31:20]};
                    w_fmt   = FMT_I;
                end
            end
            7'h23: begin
                w_imm32   = {{20{w_src[31]}}, w_src[31:25], w_src[11:7]};
                w_fmt     = FMT_S;
                w_illegal = 1'b0;
            end
            7'h63: begin
                w_imm32   = {{20{w_src[31]}}, w_src[7], w_src[30:25], w_src[11:8], 1'b0};
                w_fmt     = FMT_B;
                w_illegal = 1'b0;
            end
            7'h37, 7'h17: begin
                w_imm32   = {w_src[31:12], 12'b0};
                w_fmt     = FMT_U;
                w_illegal = 1'b0;
            end
            7'h6F: begin
                w_imm32   = {{12{w_src[31]}}, w_src[19:12], w_src[20], w_src[30:21], 1'b0};
                w_fmt     = FMT_J;
                w_illegal = 1'b0;
            end
            7'h33: begin
                w_fmt     = FMT_R;
                w_illegal = 1'b0;
            end
            default: begin
                w_imm32   = '0;
                w_fmt     = FMT_NONE;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Every 32-bit form already carries IR[31] in its top bit, so widening is a plain sign extension.
    assign w_imm = XLEN'($signed(w_imm32));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (ir_write) w_state_nxt = REG_OUT ? S_DECODE : S_HOLD;
            end
            S_DECODE: begin
                w_state_nxt = ir_write ? S_DECODE : S_HOLD;
            end
            S_HOLD: begin
                if (ir_write)     w_state_nxt = REG_OUT ? S_DECODE : S_HOLD;
                else if (imm_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_valid = (r_state == S_HOLD);
        w_load  = REG_OUT ? ((r_state == S_DECODE) && !ir_write) : ir_write;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir <= '0;
        end else if (ir_write) begin
            r_ir <= instr_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imm     <= '0;
            r_fmt     <= FMT_R;
            r_illegal <= 1'b0;
        end else if (w_load) begin
            r_imm     <= w_imm;
            r_fmt     <= w_fmt;
            r_illegal <= w_illegal;
        end
    end

    assign instr_q   = r_ir;
    assign imm_out   = r_imm;
    assign imm_fmt   = r_fmt;
    assign illegal   = r_illegal;
    assign imm_valid = w_valid;

endmodule
